// File: rtl/div_unit_pkg.sv
// Shared CPU defines for the multi-cycle divider: state encodings, ready flags, iteration count.
package div_unit_pkg;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from {partial_rem, next dividend bit}.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] dividend_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] partial_rem_next,
  output logic [WIDTH-1:0] dividend_shift_next,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_bits;

  // The extra top bit of diff is the borrow; partial_rem < divisor keeps results within WIDTH bits.
  always_comb begin
    shifted             = {partial_rem, dividend_shift[WIDTH-1]};
    diff                = {1'b0, shifted} - {2'b00, divisor};
    quot_bit            = ~diff[WIDTH+1];
    partial_rem_next    = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dividend_shift_next = {dividend_shift[WIDTH-2:0], 1'b0};
  end

  assign unused_bits = ^{diff[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// MIPS DIV/DIVU unit: FSM, operand/sign registers and sign fix around the div_step iteration.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_div
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   rem_q, rem_next;
  logic [WIDTH-1:0]   dvd_q, dvd_next;
  logic [WIDTH-1:0]   dvs_q, dvs_next;
  logic [WIDTH-1:0]   quot_q, quot_next;
  logic               neg_a_q, neg_a_next;
  logic               neg_b_q, neg_b_next;
  logic               sgn_q, sgn_next;
  logic               ready_next;
  logic [2*WIDTH-1:0] result_next;

  logic [WIDTH-1:0]   step_rem, step_dvd;
  logic               step_bit;
  logic [WIDTH-1:0]   quot_raw, quot_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem         (rem_q),
    .dividend_shift      (dvd_q),
    .divisor             (dvs_q),
    .partial_rem_next    (step_rem),
    .dividend_shift_next (step_dvd),
    .quot_bit            (step_bit)
  );

  // Sign fix on the final iteration: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    quot_raw = {quot_q[WIDTH-2:0], step_bit};
    quot_fix = (sgn_q && (neg_a_q ^ neg_b_q)) ? -quot_raw : quot_raw;
    rem_fix  = (sgn_q && neg_a_q) ? -step_rem : step_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      sgn_q    <= 1'b0;
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rem_q    <= rem_next;
      dvd_q    <= dvd_next;
      dvs_q    <= dvs_next;
      quot_q   <= quot_next;
      neg_a_q  <= neg_a_next;
      neg_b_q  <= neg_b_next;
      sgn_q    <= sgn_next;
      ready_o  <= ready_next;
      result_o <= result_next;
    end
  end

  // Next-state, datapath updates and the stall request; annul wins in every state.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    rem_next    = rem_q;
    dvd_next    = dvd_q;
    dvs_next    = dvs_q;
    quot_next   = quot_q;
    neg_a_next  = neg_a_q;
    neg_b_next  = neg_b_q;
    sgn_next    = sgn_q;
    ready_next  = DIV_RESULT_NOT_READY;
    result_next = '0;
    stall_div   = 1'b0;

    case (state)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          stall_div  = 1'b1;
          neg_a_next = signed_div_i & opdata1_i[WIDTH-1];
          neg_b_next = signed_div_i & opdata2_i[WIDTH-1];
          sgn_next   = signed_div_i;
          dvd_next   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dvs_next   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          rem_next   = '0;
          quot_next  = '0;
          cnt_next   = '0;
          state_next = (opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
        end
      end

      DIV_DIVZERO: begin
        stall_div = 1'b1;
        if (annul_i) begin
          state_next = DIV_IDLE;
        end else begin
          state_next = DIV_END;
          ready_next = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        stall_div = 1'b1;
        if (annul_i) begin
          state_next = DIV_IDLE;
        end else begin
          rem_next  = step_rem;
          dvd_next  = step_dvd;
          quot_next = quot_raw;
          cnt_next  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_next  = DIV_END;
            ready_next  = DIV_RESULT_READY;
            result_next = {rem_fix, quot_fix};
          end
        end
      end

      DIV_END: begin
        if (annul_i || !start_i) begin
          state_next = DIV_IDLE;
        end else begin
          ready_next  = DIV_RESULT_READY;
          result_next = result_o;
        end
      end

      default: state_next = DIV_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_div;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_div    (stall_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sq = sa / sb;
    sr = sa % sb;
    return {sr[31:0], sq[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge until ready_o; lat = 40 means the bound expired.
  task automatic wait_ready(output int lat, output bit stall_ok);
    lat = 1;
    stall_ok = 1'b1;
    tick();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~signed_div_i;
    while (!ready_o && lat < 40) begin
      if (!stall_div) stall_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold, input string tag);
    int lat;
    bit stall_ok;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    #1;
    check({tag, " stall_req"}, 64'(stall_div), 64'd1);
    wait_ready(lat, stall_ok);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
    check({tag, " stall_end"}, 64'(stall_div), 64'd0);
    check({tag, " result"}, result_o, exp_res);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    tick();
    check({tag, " drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop_result"}, result_o, 64'd0);
  endtask

  task automatic expect_no_ready(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen = 1'b1;
      tick();
    end
    check({tag, " no_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int   lat;
    bit   stall_ok;
    logic        rs;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
    vecs[5] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          2};
    vecs[6] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[7] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};
    vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33};

    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #2;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", 64'(stall_div), 64'd0);
    #10;
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q}, vecs[i].lat,
             (i == 0) ? 3 : 0, $sformatf("vec%0d", i));
    tick();

    // Annul mid-iteration, then a fresh division.
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_on stall", 64'(stall_div), 64'd0);
    check("annul_on ready", 64'(ready_o), 64'd0);
    expect_no_ready("annul_on");
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, "after_annul");
    tick();

    // Request with annul in the same cycle is refused.
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    #1;
    check("annul_req stall", 64'(stall_div), 64'd0);
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    expect_no_ready("annul_req");

    // Annul in DIVZERO.
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_dz stall", 64'(stall_div), 64'd0);
    expect_no_ready("annul_dz");

    // Annul in END beats a held start.
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    wait_ready(lat, stall_ok);
    check("annul_end reached", 64'(ready_o), 64'd1);
    annul_i = 1'b1;
    tick();
    check("annul_end ready", 64'(ready_o), 64'd0);
    check("annul_end result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    tick();

    // Asynchronous reset mid-ON and in END.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_on stall", 64'(stall_div), 64'd0);
    check("rst_on ready", 64'(ready_o), 64'd0);
    rst = 1'b0;
    tick();
    run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 0, "after_rst");
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF00; opdata2_i = 32'd16; start_i = 1'b1;
    wait_ready(lat, stall_ok);
    check("rst_end reached", 64'(ready_o), 64'd1);
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("rst_end ready", 64'(ready_o), 64'd0);
    check("rst_end result", result_o, 64'd0);
    check("rst_end stall", 64'(stall_div), 64'd0);
    rst = 1'b0;
    tick();

    // Random operations against the arithmetic model.
    for (int k = 0; k < 150; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'd0) ? 2 : 33, 0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the execute stage. It runs MIPS DIV/DIVU by radix-2 restoring division, one quotient bit per cycle, and returns {remainder, quotient} for the HI/LO write. It drives `stall_div` into the hazard unit, which holds F/D/E while a division is in flight. Exception flushes cancel it through `annul_i`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; result is 2*WIDTH.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  request from E stage; held high until `ready_o` is seen.
- `annul_i`  in  1  cancel request (exception flush, flushE).
- `result_o`  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; valid only while `ready_o`=1, otherwise 0.
- `ready_o`  out  1  result valid.
- `stall_div`  out  1  pipeline stall request to the hazard unit.

## Operation
States: IDLE, DIVZERO, ON, END.
- **IDLE**
  - If `start_i`=1 and `annul_i`=0: latch the absolute values of the operands (absolute only when `signed_div_i`=1). Latch the sign flags and `signed_div_i`. Clear the iteration counter.
  - Next state is DIVZERO if `opdata2_i`==0, else ON.
  - If `start_i`=1 and `annul_i`=1: the request is not accepted and the state stays IDLE.
- **DIVZERO**: result is forced to 0; next state is END.
- **ON**, one iteration per cycle:
  - Compute the 33-bit difference {partial_rem, next dividend bit} minus {0, |divisor|}.
  - If the difference is non-negative, the quotient bit is 1 and the partial remainder is replaced by the difference. Otherwise the quotient bit is 0 and the partial remainder is shifted only.
  - After the 32nd iteration, apply the sign fix and go to END.
  - Sign fix, signed mode only: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - `annul_i`=1 in ON: go to IDLE and discard the work.
- **END**
  - `ready_o`=1, and `result_o` holds the fixed result.
  - Stay in END while `start_i`=1.
  - Go to IDLE when `start_i`=0 or `annul_i`=1.
- **stall_div** = (IDLE & `start_i` & ~`annul_i`) | DIVZERO | ON. It is low in END, so the DIV instruction leaves E on the same cycle `ready_o` is seen.
- **Arithmetic**
  - Magnitudes are held unsigned in 32 bits, so |0x80000000| = 0x80000000 unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps; no trap).
- **Divide by zero**: quotient = remainder = 0 (MIPS leaves this unpredictable; the team fixes it at 0).

## Timing
- **Reset values**: state IDLE, `ready_o`=0, `result_o`=0, `stall_div`=0 (with `start_i` low), counter 0, operand registers 0.
- **Accept edge is t0.**
  - Normal division: ON during t0+1 to t0+32; `ready_o` is first high in cycle t0+33, a latency of 33 cycles.
  - Divisor zero: DIVZERO in t0+1; `ready_o` is high in t0+2.
- **`stall_div` is combinational.** It is high in the request cycle before t0, and through the last ON cycle.
- **`ready_o`/`result_o` are registered.** They are stable for every END cycle and drop to 0 in the cycle after leaving END.
- **`annul_i` has priority over every other input in every state.**
  - State becomes IDLE at the next edge.
  - `ready_o` is never asserted for an annulled operation.
  - `stall_div` falls in the cycle after annul.
- **Back-to-back**: a new request needs one IDLE cycle after END, because `start_i` must go low first.
- **Operand stability**: inputs are sampled only at the accept edge. Later changes to `opdata*_i` have no effect.
- **Reset mid-operation**: the asynchronous return to IDLE clears all outputs immediately.

## Structure
- **Shared CPU defines package**:
  - state encodings `DIV_IDLE`/`DIV_DIVZERO`/`DIV_ON`/`DIV_END` (2-bit);
  - `DIV_RESULT_READY`/`NOT_READY`;
  - iteration count 32.
- **Sub-module `div_step`**: combinational, one restoring iteration. Takes {partial_rem, dividend_shift, divisor} and gives the next partial_rem, the next dividend_shift, and the quotient bit. `div_unit` holds the FSM, counter, operand and sign registers, and the sign fix.

## Test plan
- DIVU 7 / 2 → `ready_o` at t0+33, `result_o` = {0x00000001, 0x00000003}; `stall_div` high through t0+32, low at t0+33.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- DIV 5 / 0 → `ready_o` at t0+2 with `result_o` = 0; `stall_div` low by t0+2.
- `annul_i` pulsed at t0+10 → IDLE at t0+11; `ready_o` never rises; `stall_div` low at t0+11. A fresh 100 / 7 then gives {2, 14}.
- `rst` at t0+5 → all outputs 0 immediately. Also: hold `start_i` in END for 3 cycles → result stable; drop `start_i` → IDLE, `ready_o`=0 next cycle.
